// File: rtl/demux1_4_reg.sv
// Purpose: steers incoming bytes into four registered slots (auto pointer or explicit sel) and presents them as one word.
// Latency: an accepted byte appears on its Out slot one cycle later; out_valid rises the cycle after the fourth distinct slot fills.
// Backpressure: in_ready drops while the word is held (FULL) until out_valid & out_ready; clear flushes the fill state at any time.
module demux1_4_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] In,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sel_mode,
  input  logic [1:0]   sel,
  input  logic         clear,
  output logic [W-1:0] Out1,
  output logic [W-1:0] Out2,
  output logic [W-1:0] Out3,
  output logic [W-1:0] Out4,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0][W-1:0]   slot_q, slot_d;

  logic [1:0]          target;
  logic [3:0]          mask_set;

  // Destination slot and the mask that would result if this byte were accepted.
  assign target   = sel_mode ? sel : ptr_q;
  assign mask_set = mask_q | (4'b0001 << target);

  // Handshake flags come straight from the state register so no input can ripple into them.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);

  assign Out1 = slot_q[0];
  assign Out2 = slot_q[1];
  assign Out3 = slot_q[2];
  assign Out4 = slot_q[3];

  // Next-state logic: clear beats both accept and the output handshake; slot data is never cleared here.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    if (clear) begin
      state_d = FILL;
      mask_d  = 4'b0000;
      ptr_d   = 2'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            slot_d[target] = In;
            mask_d         = mask_set;
            // Explicit-mode writes leave the auto pointer where it was.
            if (!sel_mode) begin
              ptr_d = ptr_q + 2'd1;
            end
            if (mask_set == 4'b1111) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          // Slots keep their data after the handshake; only the fill bookkeeping restarts.
          if (out_ready) begin
            state_d = FILL;
            mask_d  = 4'b0000;
            ptr_d   = 2'd0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, fill bookkeeping and slot registers; rst discards everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      mask_q  <= 4'b0000;
      ptr_q   <= 2'd0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: doc/demux1_4_reg.md
DEMUX1_4_REG -- requirements
Module: demux1_4_reg

Interface
REQ-001 SHALL have parameter W, default 8, byte lane width.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port In, input, W, incoming byte.
REQ-005 SHALL have port in_valid, input, 1, In is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts In this cycle.
REQ-007 SHALL have port sel_mode, input, 1: 0 = auto slot pointer, 1 = slot from sel.
REQ-008 SHALL have port sel, input, 2, explicit destination slot (00->Out1 .. 11->Out4), used only when sel_mode=1.
REQ-009 SHALL have port clear, input, 1, synchronous flush of fill state.
REQ-010 SHALL have ports Out1, Out2, Out3, Out4, output, W each, registered slot contents.
REQ-011 SHALL have port out_valid, output, 1, all four slots filled.
REQ-012 SHALL have port out_ready, input, 1, consumer takes Out1..Out4 this cycle.

Function
REQ-013 SHALL implement two states: FILL and FULL; in_ready=1 exactly in FILL, out_valid=1 exactly in FULL.
REQ-014 Accept = in_valid & in_ready; on accept, SHALL write In into the target slot at the clock edge, visible on Out1..Out4 the next cycle.
REQ-015 Target slot SHALL be ptr when sel_mode=0 and sel when sel_mode=1.
REQ-016 SHALL keep a 4-bit filled mask; accept sets the target slot's bit.
REQ-017 Auto mode: ptr SHALL increment by 1 per accept, wrapping 3->0; explicit-mode accepts SHALL NOT change ptr.
REQ-018 Writing an already-filled slot SHALL overwrite its data and leave the mask unchanged.
REQ-019 FILL->FULL SHALL occur on the edge where the mask becomes 4'b1111; out_valid rises the cycle after the completing accept.
REQ-020 In FULL, SHALL ignore In and in_valid; Out1..Out4 SHALL be stable.
REQ-021 FULL->FILL SHALL occur on out_valid & out_ready; mask and ptr reset to 0; Out1..Out4 retain their values.
REQ-022 out_valid, once high, SHALL stay high until the handshake, clear, or rst.
REQ-023 clear=1 SHALL take priority over accept and handshake: next state FILL, mask=0, ptr=0, Out1..Out4 unchanged, no write that cycle.
REQ-024 sel_mode changes mid-fill SHALL be legal; mask governs completion regardless of mode mix.
REQ-025 in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from inputs.

Reset
REQ-026 rst=1 SHALL immediately force state FILL, mask=0, ptr=0, Out1..Out4=0, out_valid=0, in_ready=1.
REQ-027 rst asserted mid-fill or in FULL SHALL discard partial or complete data without a handshake.
REQ-028 After rst release, the first rising edge with in_valid=1 SHALL be a valid accept.

Verification
REQ-029 Auto fill: sel_mode=0, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> Out1..Out4=11,22,33,44, out_valid=1 the cycle after 0x44, in_ready=0.
REQ-030 Backpressure: FULL with out_ready=0 for 5 cycles while in_valid=1, In=0xFF -> outputs unchanged, out_valid held; out_ready=1 -> next cycle in_ready=1, Out values retained.
REQ-031 Explicit/overwrite: sel_mode=1, sel=2 In=0xAA, sel=2 In=0xBB, then sel=0,1,3 -> Out3=0xBB, out_valid only after the fourth distinct slot is written.
REQ-032 Clear priority: two auto accepts, then clear=1 together with in_valid=1 -> no write; next auto accept lands in Out1.
REQ-033 Async reset: rst pulsed between clock edges in FULL -> all outputs 0 and in_ready=1 without waiting for a clock edge.
REQ-034 Wrap: eight back-to-back auto bytes with out_ready=1 -> two complete words, ptr wraps to 0, in_valid gaps inserted randomly must not corrupt slot order.
